sram_bram_bridge: RTL and testbench

- Parametrised replacement for the hand-wired SRAM-emulation glue between sys and on-chip block RAM.
- Decodes the sys SRAM pin bus (active-low strobes, 16-bit word address) into NREG independently sized BRAM regions.
- Each region has a read-only attribute.
- Adds a pipelined read path with a valid flag, single-write-per-strobe semantics, and a loader write port so the serial bootloader can fill ROM, GROM and cartridge regions at run time.

---
 rtl/sram_bram_bridge.sv | 190 +++++++++++++++++++
 tb/tb_sram_bram_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bram_bridge.sv
// SRAM pin-bus to multi-region block-RAM bridge: address decode, write protection,
// one write per WE strobe, pipelined reads and a bootloader write port.
module sram_bram_bridge #(
  parameter int                 AW          = 18,
  parameter int                 DW          = 16,
  parameter int                 NREG        = 4,
  parameter logic [AW*NREG-1:0] REGION_BASE = {18'h20000, 18'h10000, 18'h04000, 18'h00000},
  parameter logic [5*NREG-1:0]  REGION_AW   = {5'd13, 5'd13, 5'd9, 5'd12},
  parameter logic [NREG-1:0]    RO_MASK     = 4'b0001,
  parameter int                 RD_LAT      = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sram_cs_n,
  input  logic            sram_oe_n,
  input  logic            sram_we_n,
  input  logic            sram_lb_n,
  input  logic            sram_ub_n,
  input  logic [AW-1:0]   sram_addr,
  input  logic [DW-1:0]   sram_wdata,
  output logic [DW-1:0]   sram_rdata,
  output logic            sram_rvalid,
  input  logic            ld_req,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_wdata,
  input  logic [1:0]      ld_be,
  output logic            ld_ack,
  output logic [NREG-1:0] hit,
  output logic            wp_violation,
  output logic [7:0]      err_count
);

  // One-hot region select; on overlap the lowest index wins.
  function automatic logic [NREG-1:0] region_decode(input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    logic            found;
    logic            match;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      match = (((a ^ REGION_BASE[AW*i +: AW]) >> REGION_AW[5*i +: 5]) == '0);
      oh[i] = match & ~found;
      found = found | match;
    end
    return oh;
  endfunction

  logic            prev_we_q, prev_we_d;
  logic [NREG-1:0] hit_q, hit_d;
  logic            rvalid1_q, rvalid1_d;
  logic            ld_ack_q, ld_ack_d;
  logic            wp_q, wp_d;
  logic [7:0]      err_q, err_d;

  logic [NREG-1:0] rd_hit_s;
  logic [NREG-1:0] ld_hit_s;
  logic [NREG-1:0] wr_sel_s;
  logic [1:0]      cpu_be_s;
  logic [1:0]      wr_be_s;
  logic [DW-1:0]   wr_data_s;
  logic            cpu_wr_s;
  logic            ld_go_s;
  logic            wp_hit_s;
  logic [DW-1:0]   rd_bank_s [NREG];
  logic [DW-1:0]   rd_mux_s;

  // Write arbitration: the CPU strobe edge wins, the loader takes any free cycle.
  always_comb begin
    rd_hit_s  = region_decode(sram_addr);
    ld_hit_s  = region_decode(ld_addr);
    cpu_be_s  = {~sram_ub_n, ~sram_lb_n};
    // reset_n gates the array write enables, which have no reset of their own
    cpu_wr_s  = reset_n & ~sram_cs_n & ~sram_we_n & prev_we_q;
    wp_hit_s  = cpu_wr_s & (|cpu_be_s) & (|(rd_hit_s & RO_MASK));
    ld_go_s   = reset_n & ld_req & ~cpu_wr_s;
    wr_sel_s  = '0;
    wr_be_s   = 2'b00;
    wr_data_s = '0;
    if (cpu_wr_s) begin
      wr_sel_s  = rd_hit_s & ~RO_MASK;
      wr_be_s   = cpu_be_s;
      wr_data_s = sram_wdata;
    end else if (ld_go_s) begin
      wr_sel_s  = ld_hit_s;
      wr_be_s   = ld_be;
      wr_data_s = ld_wdata;
    end else begin
      wr_sel_s  = '0;
    end
  end

  // Next-state values for the control and status registers.
  always_comb begin
    prev_we_d = sram_we_n;
    hit_d     = rd_hit_s;
    rvalid1_d = ~sram_cs_n & ~sram_oe_n & (|rd_hit_s);
    ld_ack_d  = ld_go_s;
    wp_d      = wp_hit_s;
    if (wp_hit_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_we_q <= 1'b0;
      hit_q     <= '0;
      rvalid1_q <= 1'b0;
      ld_ack_q  <= 1'b0;
      wp_q      <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      prev_we_q <= prev_we_d;
      hit_q     <= hit_d;
      rvalid1_q <= rvalid1_d;
      ld_ack_q  <= ld_ack_d;
      wp_q      <= wp_d;
      err_q     <= err_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_region
    localparam int RAW   = int'(REGION_AW[5*g +: 5]);
    localparam int DEPTH = 1 << RAW;

    logic [7:0]     mem_lo [DEPTH];
    logic [7:0]     mem_hi [DEPTH];
    logic [RAW-1:0] roff_s;
    logic [RAW-1:0] woff_s;
    logic           bypass_s;
    logic [DW-1:0]  rd_q;

    assign roff_s   = sram_addr[RAW-1:0];
    assign woff_s   = cpu_wr_s ? sram_addr[RAW-1:0] : ld_addr[RAW-1:0];
    assign bypass_s = wr_sel_s[g] && (woff_s == roff_s);

    // Byte-lane RAM with a write-first read register at the CPU address.
    always_ff @(posedge clk) begin
      if (wr_sel_s[g] && wr_be_s[0]) begin
        mem_lo[woff_s] <= wr_data_s[7:0];
      end
      if (wr_sel_s[g] && wr_be_s[1]) begin
        mem_hi[woff_s] <= wr_data_s[15:8];
      end
      rd_q[7:0]  <= (bypass_s && wr_be_s[0]) ? wr_data_s[7:0]  : mem_lo[roff_s];
      rd_q[15:8] <= (bypass_s && wr_be_s[1]) ? wr_data_s[15:8] : mem_hi[roff_s];
    end

    assign rd_bank_s[g] = rd_q;
  end

  // Select the bank that the registered hit points at; a miss yields zero.
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < NREG; i++) begin
      rd_mux_s = rd_mux_s | (rd_bank_s[i] & {DW{hit_q[i]}});
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] rdata2_q;
    logic          rvalid2_q;

    // Extra output stage for the two-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata2_q  <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        rdata2_q  <= rd_mux_s;
        rvalid2_q <= rvalid1_q;
      end
    end

    assign sram_rdata  = rdata2_q;
    assign sram_rvalid = rvalid2_q;
  end else begin : g_lat1
    assign sram_rdata  = rd_mux_s;
    assign sram_rvalid = rvalid1_q;
  end

  assign hit          = hit_q;
  assign ld_ack       = ld_ack_q;
  assign wp_violation = wp_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_sram_bram_bridge.sv
// Randomised and directed bench for sram_bram_bridge; two instances cover read latency 1 and 2
// against one behavioural memory model.
module tb_sram_bram_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_n, oe_n, we_n, lb_n, ub_n;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic        ld_req;
  logic [17:0] ld_addr;
  logic [15:0] ld_wdata;
  logic [1:0]  ld_be;

  logic [15:0] rdata1, rdata2;
  logic        rvalid1, rvalid2, ack1, ack2, wp1, wp2;
  logic [3:0]  hit1, hit2;
  logic [7:0]  err1, err2;

  always #5 clk = ~clk;

  sram_bram_bridge #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .sram_cs_n(cs_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_lb_n(lb_n), .sram_ub_n(ub_n), .sram_addr(addr), .sram_wdata(wdata),
    .sram_rdata(rdata1), .sram_rvalid(rvalid1), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_be(ld_be), .ld_ack(ack1), .hit(hit1),
    .wp_violation(wp1), .err_count(err1)
  );

  sram_bram_bridge #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .sram_cs_n(cs_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_lb_n(lb_n), .sram_ub_n(ub_n), .sram_addr(addr), .sram_wdata(wdata),
    .sram_rdata(rdata2), .sram_rvalid(rvalid2), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_be(ld_be), .ld_ack(ack2), .hit(hit2),
    .wp_violation(wp2), .err_count(err2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Region map as plain ranges; first matching range wins.
  int base_m [4] = '{32'h00000, 32'h04000, 32'h10000, 32'h20000};
  int size_m [4] = '{4096, 512, 8192, 8192};
  bit ro_m   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic [7:0]  mem_m [int];
  bit          pwe_m;
  int          err_m;
  bit          ack_m, wp_m;
  logic [3:0]  hit_m;
  logic [15:0] d_val [2];
  logic [15:0] d_mask [2];
  bit          d_rv [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int region_of(input int a);
    for (int i = 0; i < 4; i++) begin
      if (a >= base_m[i] && a < base_m[i] + size_m[i]) return i;
    end
    return -1;
  endfunction

  task automatic write_bytes(input int a, input logic [15:0] d, input logic [1:0] be);
    if (be[0]) mem_m[a*2]   = d[7:0];
    if (be[1]) mem_m[a*2+1] = d[15:8];
  endtask

  task automatic model_reset();
    pwe_m = 1'b0;
    err_m = 0;
    ack_m = 1'b0;
    wp_m  = 1'b0;
    hit_m = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      d_val[i]  = 16'h0000;
      d_mask[i] = 16'hFFFF;
      d_rv[i]   = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_rdata1"}, rdata1, 16'h0000);
    check_val({tag, "_rvalid1"}, rvalid1, 1'b0);
    check_val({tag, "_ack1"}, ack1, 1'b0);
    check_val({tag, "_hit1"}, hit1, 4'b0000);
    check_val({tag, "_wp1"}, wp1, 1'b0);
    check_val({tag, "_err1"}, err1, 8'h00);
    check_val({tag, "_rdata2"}, rdata2, 16'h0000);
    check_val({tag, "_rvalid2"}, rvalid2, 1'b0);
    check_val({tag, "_err2"}, err2, 8'h00);
  endtask

  // Apply the current inputs to the model for one clock, then compare both instances.
  task automatic cycle();
    int a, la, r, lr;
    bit cpu_wr, ldgo, viol;
    logic [15:0] v, m;
    a  = int'(addr);
    la = int'(ld_addr);
    r  = region_of(a);
    lr = region_of(la);
    cpu_wr = !cs_n && !we_n && pwe_m;
    pwe_m  = we_n;
    viol   = 1'b0;
    if (cpu_wr && r >= 0 && !(lb_n && ub_n)) begin
      if (ro_m[r]) viol = 1'b1;
      else write_bytes(a, wdata, {!ub_n, !lb_n});
    end
    ldgo = ld_req && !cpu_wr;
    if (ldgo && lr >= 0) write_bytes(la, ld_wdata, ld_be);
    if (viol && err_m < 255) err_m++;
    v = 16'h0000;
    m = 16'hFFFF;
    if (r >= 0) begin
      m = 16'h0000;
      if (mem_m.exists(a*2))   begin v[7:0]  = mem_m[a*2];   m[7:0]  = 8'hFF; end
      if (mem_m.exists(a*2+1)) begin v[15:8] = mem_m[a*2+1]; m[15:8] = 8'hFF; end
    end
    d_val[1] = d_val[0];  d_mask[1] = d_mask[0];  d_rv[1] = d_rv[0];
    d_val[0] = v;         d_mask[0] = m;          d_rv[0] = !cs_n && !oe_n && r >= 0;
    hit_m = (r >= 0) ? (4'b0001 << r) : 4'b0000;
    ack_m = ldgo;
    wp_m  = viol;
    @(posedge clk);
    #1;
    check_val("rdata1", rdata1 & d_mask[0], d_val[0] & d_mask[0]);
    check_val("rvalid1", rvalid1, d_rv[0]);
    check_val("rdata2", rdata2 & d_mask[1], d_val[1] & d_mask[1]);
    check_val("rvalid2", rvalid2, d_rv[1]);
    check_val("hit1", hit1, hit_m);
    check_val("hit2", hit2, hit_m);
    check_val("ack1", ack1, ack_m);
    check_val("ack2", ack2, ack_m);
    check_val("wp1", wp1, wp_m);
    check_val("wp2", wp2, wp_m);
    check_val("err1", err1, err_m[7:0]);
    check_val("err2", err2, err_m[7:0]);
  endtask

  task automatic ld_write(input string tag, input logic [17:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    ld_req   = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    ld_be    = be;
    cycle();
    for (int k = 0; k < 8 && !ack1; k++) cycle();
    check_val(tag, ack1, 1'b1);
    ld_req = 1'b0;
  endtask

  function automatic logic [17:0] rand_addr();
    int sel, reg_i;
    sel   = $urandom_range(0, 9);
    reg_i = $urandom_range(0, 3);
    if (sel < 5) return 18'(base_m[reg_i] + $urandom_range(0, 7));
    if (sel < 7) return 18'(base_m[reg_i] + size_m[reg_i] - 1);
    if (sel < 8) return 18'(base_m[reg_i] + size_m[reg_i]);
    if (sel < 9) return 18'(32'h30000 + $urandom_range(0, 3));
    return 18'h08000;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    addr = 18'h00000; wdata = 16'h0000;
    ld_req = 1'b0; ld_addr = 18'h00000; ld_wdata = 16'h0000; ld_be = 2'b11;
    model_reset();
    #1;
    check_zero("rst0");
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst1");
    reset_n = 1'b1;
    repeat (2) cycle();

    // single write per long strobe, then low lane masked
    cs_n = 1'b0; addr = 18'h04010; wdata = 16'hA55A; we_n = 1'b0;
    cycle();
    wdata = 16'hFFFF;
    repeat (4) cycle();
    we_n = 1'b1; cycle();
    lb_n = 1'b1; wdata = 16'h1234; we_n = 1'b0;
    repeat (3) cycle();
    we_n = 1'b1; cycle();
    lb_n = 1'b0; oe_n = 1'b0;
    cycle();
    check_val("tA_rdata1", rdata1, 16'h125A);
    check_val("tA_rvalid1", rvalid1, 1'b1);
    check_val("tA_rvalid2_early", rvalid2, 1'b0);
    check_val("tA_hit1", hit1, 4'b0010);
    cs_n = 1'b1; oe_n = 1'b1;
    cycle();
    check_val("tA_rdata2", rdata2, 16'h125A);
    check_val("tA_rvalid2", rvalid2, 1'b1);

    // write protect on region 0, loader overrides it
    cs_n = 1'b0;
    ld_write("tB_ld1", 18'h00020, 16'h1111, 2'b11);
    addr = 18'h00020; wdata = 16'h5555;
    cycle();
    we_n = 1'b0; cycle();
    check_val("tB_wp", wp1, 1'b1);
    check_val("tB_err", err1, 8'h01);
    we_n = 1'b1; cycle();
    check_val("tB_wp_pulse", wp1, 1'b0);
    oe_n = 1'b0; cycle();
    check_val("tB_rd_unchanged", rdata1, 16'h1111);
    oe_n = 1'b1;
    ld_write("tB_ld2", 18'h00020, 16'hBEEF, 2'b11);
    oe_n = 1'b0; cycle();
    check_val("tB_rd_beef", rdata1, 16'hBEEF);
    oe_n = 1'b1;

    // CPU and loader hit the same word in the same cycle
    addr = 18'h04030; wdata = 16'h8888;
    cycle();
    we_n = 1'b0; ld_req = 1'b1; ld_addr = 18'h04030; ld_wdata = 16'h7777; ld_be = 2'b11;
    cycle();
    check_val("tC_ack_wait", ack1, 1'b0);
    cycle();
    check_val("tC_ack", ack1, 1'b1);
    ld_req = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    cycle();
    check_val("tC_rd", rdata1, 16'h7777);

    // unmapped address
    addr = 18'h30000;
    cycle();
    check_val("tD_rdata1", rdata1, 16'h0000);
    check_val("tD_rvalid1", rvalid1, 1'b0);
    check_val("tD_hit1", hit1, 4'b0000);
    cycle();
    check_val("tD_rdata2", rdata2, 16'h0000);
    check_val("tD_rvalid2", rvalid2, 1'b0);
    oe_n = 1'b1;
    ld_write("tD_ld", 18'h30000, 16'h5A5A, 2'b11);
    check_val("tD_wp", wp1, 1'b0);
    check_val("tD_err", err1, 8'h01);

    // saturating violation counter
    addr = 18'h00020;
    for (int k = 0; k < 256; k++) begin
      we_n = 1'b1; cycle();
      we_n = 1'b0; cycle();
    end
    we_n = 1'b1; cycle();
    check_val("tE_sat1", err1, 8'hFF);
    check_val("tE_sat2", err2, 8'hFF);

    // reset in the middle of a strobe and a loader request
    ld_write("tF_ld1", 18'h04020, 16'h1111, 2'b11);
    ld_write("tF_ld2", 18'h04021, 16'h4444, 2'b11);
    addr = 18'h04020; wdata = 16'h2222;
    cycle();
    we_n = 1'b0; ld_req = 1'b1; ld_addr = 18'h04021; ld_wdata = 16'h3333; ld_be = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("tF_in");
    repeat (3) @(posedge clk);
    #1;
    check_zero("tF_hold");
    ld_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    oe_n = 1'b0;
    repeat (3) cycle();
    check_val("tF_nowrite", rdata1, 16'h1111);
    we_n = 1'b1; oe_n = 1'b1; cycle();
    we_n = 1'b0; cycle();
    we_n = 1'b1; oe_n = 1'b0; cycle();
    check_val("tF_fresh", rdata1, 16'h2222);
    addr = 18'h04021; cycle();
    check_val("tF_ld_dropped", rdata1, 16'h4444);

    // randomised traffic
    for (int k = 0; k < 3000; k++) begin
      cs_n  = ($urandom_range(0, 7) == 0);
      oe_n  = 1'($urandom_range(0, 1));
      we_n  = 1'($urandom_range(0, 1));
      lb_n  = ($urandom_range(0, 3) == 0);
      ub_n  = ($urandom_range(0, 3) == 0);
      addr  = rand_addr();
      wdata = 16'($urandom);
      if (ld_req && ack_m) begin
        ld_req = 1'b0;
      end else if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req   = 1'b1;
        ld_addr  = rand_addr();
        ld_wdata = 16'($urandom);
        ld_be    = 2'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
